// File: rtl/reg_file_mp_pkg.sv
// Shared types and helpers for the multi-port register file and its scoreboard.
package rf_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);
  // Widest register file the decode helper can serve; callers truncate to NREGS.
  localparam int unsigned NREGS_MAX = 256;

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

  function automatic logic [NREGS_MAX-1:0] onehot_dec(input int unsigned addr);
    return NREGS_MAX'(1) << addr;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback-facing bus of the register file: reads, writes, issue and flush.
interface reg_file_mp_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 1
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                issue_en;
  logic [AW-1:0]       issue_rd;
  logic                flush;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd, flush,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd, flush,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register busy bits: flush beats issue, issue beats write-clear; bit 0 is never busy.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NWR   = 1,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_issue_en,
  input  logic [AW-1:0]     i_issue_rd,
  input  logic              i_flush,
  input  logic [NWR-1:0]    i_wr_en,
  input  logic [NWR*AW-1:0] i_wr_addr,
  output logic [NREGS-1:0]  o_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic [NREGS-1:0] w_issue_dec;
  logic [NREGS-1:0] w_wr_dec;

  always_comb begin
    w_issue_dec = i_issue_en ? NREGS'(onehot_dec(32'(i_issue_rd))) : '0;
    w_wr_dec    = '0;
    for (int unsigned p = 0; p < NWR; p++) begin
      if (i_wr_en[p]) w_wr_dec |= NREGS'(onehot_dec(32'(i_wr_addr[p*AW +: AW])));
    end
    if (i_flush) w_busy_nxt = '0;
    else         w_busy_nxt = (r_busy & ~w_wr_dec) | w_issue_dec;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port integer register file with busy scoreboard; x0 reads as zero.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 1,
  parameter int unsigned BYPASS = 1
) (
  input  logic          clk,
  input  logic          reset,
  reg_file_mp_if.slave  bus
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0]  r_regs [1:NREGS-1];
  logic [NREGS-1:0] w_busy;

  rf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .i_issue_en (bus.issue_en),
    .i_issue_rd (bus.issue_rd),
    .i_flush    (bus.flush),
    .i_wr_en    (bus.wr_en),
    .i_wr_addr  (bus.wr_addr),
    .o_busy     (w_busy)
  );

  // Ascending port order: the highest-indexed colliding writer lands last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 1; r < NREGS; r++) r_regs[r] <= '0;
    end else begin
      for (int unsigned p = 0; p < NWR; p++) begin
        if (bus.wr_en[p] && bus.wr_addr[p*AW +: AW] != '0)
          r_regs[bus.wr_addr[p*AW +: AW]] <= bus.wr_data[p*XLEN +: XLEN];
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_hit;

    assign w_addr = bus.rd_addr[k*AW +: AW];

    // Forwarding is suppressed under reset so all outputs read zero then.
    always_comb begin
      w_hit  = 1'b0;
      w_data = (w_addr == '0) ? '0 : r_regs[w_addr];
      if (BYPASS != 0 && !reset && w_addr != '0) begin
        for (int unsigned p = 0; p < NWR; p++) begin
          if (bus.wr_en[p] && bus.wr_addr[p*AW +: AW] == w_addr) begin
            w_hit  = 1'b1;
            w_data = bus.wr_data[p*XLEN +: XLEN];
          end
        end
      end
    end

    assign bus.rd_data[k*XLEN +: XLEN] = w_data;
    assign bus.rd_busy[k]              = w_busy[w_addr] & ~w_hit;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: bypass and non-bypass instances share stimulus and a reference model.
module tb_reg_file_mp;
  import rf_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned NWR   = 2;
  localparam int unsigned AW    = $clog2(NREGS);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus_b ();
  reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus_n ();

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));
  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_dut_n (
    .clk(clk), .reset(reset), .bus(bus_n.slave));

  int unsigned ra [NRD];
  int unsigned wa [NWR];
  xword_t      wd [NWR];
  logic        we [NWR];
  logic        issue_en;
  int unsigned issue_rd;
  logic        flush;

  logic [NRD*AW-1:0]   p_rd_addr;
  logic [NWR-1:0]      p_wr_en;
  logic [NWR*AW-1:0]   p_wr_addr;
  logic [NWR*XLEN-1:0] p_wr_data;

  always_comb begin
    p_rd_addr = '0;
    p_wr_en   = '0;
    p_wr_addr = '0;
    p_wr_data = '0;
    for (int k = 0; k < NRD; k++) p_rd_addr[k*AW +: AW] = AW'(ra[k]);
    for (int p = 0; p < NWR; p++) begin
      p_wr_en[p]              = we[p];
      p_wr_addr[p*AW +: AW]   = AW'(wa[p]);
      p_wr_data[p*XLEN +: XLEN] = wd[p];
    end
  end

  assign bus_b.rd_addr  = p_rd_addr;  assign bus_n.rd_addr  = p_rd_addr;
  assign bus_b.wr_en    = p_wr_en;    assign bus_n.wr_en    = p_wr_en;
  assign bus_b.wr_addr  = p_wr_addr;  assign bus_n.wr_addr  = p_wr_addr;
  assign bus_b.wr_data  = p_wr_data;  assign bus_n.wr_data  = p_wr_data;
  assign bus_b.issue_en = issue_en;   assign bus_n.issue_en = issue_en;
  assign bus_b.issue_rd = AW'(issue_rd); assign bus_n.issue_rd = AW'(issue_rd);
  assign bus_b.flush    = flush;      assign bus_n.flush    = flush;

  // Reference model: architectural registers and busy flags as plain arrays.
  xword_t m_regs [NREGS];
  bit     m_busy [NREGS];
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit write_hits(int unsigned a);
    for (int p = 0; p < NWR; p++) if (we[p] && wa[p] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic xword_t exp_data(int unsigned a, bit byp);
    if (a == 0 || reset) return '0;
    if (byp) for (int p = NWR - 1; p >= 0; p--) if (we[p] && wa[p] == a) return wd[p];
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(int unsigned a, bit byp);
    if (a == 0 || reset) return 1'b0;
    if (byp && write_hits(a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      model_clear();
      return;
    end
    for (int r = 1; r < NREGS; r++) begin
      if (flush)                                       m_busy[r] = 1'b0;
      else if (issue_en && issue_rd == int'(r))        m_busy[r] = 1'b1;
      else if (write_hits(r))                          m_busy[r] = 1'b0;
    end
    for (int p = 0; p < NWR; p++) if (we[p] && wa[p] != 0) m_regs[wa[p]] = wd[p];
  endtask

  task automatic set_reset(input bit v);
    reset = v;
    if (v) model_clear();
  endtask

  task automatic check_outputs();
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("byp.rd_data%0d[%0d]", k, ra[k]), bus_b.rd_data[k*XLEN +: XLEN], exp_data(ra[k], 1'b1));
      chk($sformatf("byp.rd_busy%0d[%0d]", k, ra[k]), 32'(bus_b.rd_busy[k]), 32'(exp_busy(ra[k], 1'b1)));
      chk($sformatf("nob.rd_data%0d[%0d]", k, ra[k]), bus_n.rd_data[k*XLEN +: XLEN], exp_data(ra[k], 1'b0));
      chk($sformatf("nob.rd_busy%0d[%0d]", k, ra[k]), 32'(bus_n.rd_busy[k]), 32'(exp_busy(ra[k], 1'b0)));
    end
  endtask

  task automatic idle();
    for (int p = 0; p < NWR; p++) begin
      we[p] = 1'b0;
      wa[p] = 0;
      wd[p] = '0;
    end
    issue_en = 1'b0;
    issue_rd = 0;
    flush    = 1'b0;
  endtask

  task automatic rd(input int unsigned a0, input int unsigned a1);
    ra[0] = a0;
    ra[1] = a1;
  endtask

  task automatic wr(input int p, input int unsigned a, input xword_t d);
    we[p] = 1'b1;
    wa[p] = a;
    wd[p] = d;
  endtask

  task automatic step();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    model_clear();
    idle();
    rd(0, 0);
    set_reset(1'b1);
    @(negedge clk);
    step();
    set_reset(1'b0);

    // Fill and readback on both ports.
    for (int unsigned i = 1; i < NREGS; i++) begin
      idle(); wr(0, i, xword_t'((i + 1) * 2)); rd(i, (i + 7) % NREGS);
      step();
    end
    idle();
    for (int unsigned a = 0; a < NREGS; a++) begin
      rd(a, NREGS - 1 - a);
      step();
    end

    // Same-cycle forwarding vs stored value.
    idle(); wr(0, 5, 32'h1234); rd(5, 5); step();
    idle(); rd(5, 4); step();

    // Two ports colliding on one address.
    idle(); wr(0, 7, 32'hAAAA); wr(1, 7, 32'h5555); rd(7, 7); step();
    idle(); rd(7, 6); step();

    // Scoreboard: issue, write-clear, issue+write.
    idle(); issue_en = 1'b1; issue_rd = 3; rd(3, 3); step();
    idle(); rd(3, 3); step();
    idle(); wr(0, 3, 32'h33); rd(3, 3); step();
    idle(); rd(3, 3); step();
    idle(); issue_en = 1'b1; issue_rd = 3; wr(1, 3, 32'h44); rd(3, 3); step();
    idle(); rd(3, 3); step();

    // Flush overrides a concurrent issue.
    foreach (ra[k]) ra[k] = 0;
    idle(); issue_en = 1'b1; issue_rd = 2; step();
    idle(); issue_en = 1'b1; issue_rd = 4; step();
    idle(); issue_en = 1'b1; issue_rd = 9; rd(2, 4); step();
    idle(); flush = 1'b1; issue_en = 1'b1; issue_rd = 6; rd(9, 6); step();
    idle(); rd(2, 4); step();
    idle(); rd(9, 6); step();

    // Reset mid-cycle; writes under reset (including to x0) are lost.
    idle(); wr(0, 5, 32'hCAFE); issue_en = 1'b1; issue_rd = 5; rd(5, 0);
    #2 set_reset(1'b1);
    step();
    idle(); wr(0, 0, 32'hDEADBEEF); wr(1, 8, 32'hBEEF); rd(0, 8); step();
    set_reset(1'b0);
    idle(); wr(0, 0, 32'hDEADBEEF); rd(0, 5); step();
    idle();
    for (int unsigned a = 0; a < NREGS; a += 2) begin
      rd(a, a + 1);
      step();
    end

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NRD; k++) ra[k] = $urandom_range(0, NREGS - 1);
      for (int p = 0; p < NWR; p++) begin
        we[p] = 1'($urandom_range(0, 1));
        wa[p] = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1);
        wd[p] = $urandom;
      end
      issue_en = ($urandom_range(0, 2) == 0);
      issue_rd = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1);
      flush    = ($urandom_range(0, 19) == 0);
      set_reset($urandom_range(0, 49) == 0);
      step();
    end
    set_reset(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
